// File: rtl/shift_arbiter_ctrl.sv
// shift_arbiter_ctrl: arbitrates NUM_REQ shift requesters onto one shared left barrel shifter
//   clk_i, rst_ni                 clock, async active-low reset
//   req_valid_i/req_ready_o       per-requester request handshake (ready is one-hot, IDLE only)
//   req_a_i/req_shamt_i/req_op_i  packed per-requester operand, amount, op (00 SLL, 01 SRL, 11 SRA, 10 SLL)
//   rsp_valid_o/rsp_ready_i       per-requester response handshake, valid one-hot on owner
//   rsp_data_o                    registered shift result
//   sh_a_o/sh_shamt_o/sh_s_i      shared shifter operand, amount and combinational result
//   SHIFT_ARB_FIXED_PRIO_EN       when defined, fixed priority (lowest index wins) instead of round-robin
module shift_arbiter_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*XLEN-1:0] req_a_i,
  input  logic [NUM_REQ*5-1:0]    req_shamt_i,
  input  logic [NUM_REQ*2-1:0]    req_op_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [XLEN-1:0]         rsp_data_o,
  output logic [XLEN-1:0]         sh_a_o,
  output logic [4:0]              sh_shamt_o,
  input  logic [XLEN-1:0]         sh_s_i
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] rr_ptr, grant, owner_q;
  logic [XLEN-1:0] a_q, a_sel, a_rev, s_rev, rsp_data_q, res;
  logic [4:0] shamt_q, shamt_sel;
  logic [1:0] op_q, op_sel;
  logic any_valid, accept;
  assign any_valid = |req_valid_i;
  assign accept = state_q == IDLE && any_valid;
  // Pick the valid requester with the smallest rotational distance from rr_ptr.
  always_comb begin
    int best;
    int off;
    best = NUM_REQ;
    off = 0;
    grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      off = (j + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
      if (req_valid_i[j] && off < best) begin
        best = off;
        grant = PW'(j);
      end
    end
  end
  always_comb begin
    a_sel = '0;
    shamt_sel = '0;
    op_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant == PW'(j)) begin
        a_sel = req_a_i[XLEN*j +: XLEN];
        shamt_sel = req_shamt_i[5*j +: 5];
        op_sel = req_op_i[2*j +: 2];
      end
    end
  end
`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  assign rr_ptr_d = !accept ? rr_ptr_q : (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;
  end
  assign rr_ptr = rr_ptr_q;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_valid ? SHIFT : IDLE;
      SHIFT:   state_d = RESP;
      RESP:    state_d = rsp_ready_i[owner_q] ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // Right shifts reuse the left shifter by reversing the operand in and the result out.
  assign a_rev = {<<{a_q}};
  assign s_rev = {<<{sh_s_i}};
  assign res = (op_q[0] ? s_rev : sh_s_i)
             | ((op_q == 2'b11 && a_q[XLEN-1]) ? ~({XLEN{1'b1}} >> shamt_q) : '0);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      a_q <= '0;
      shamt_q <= '0;
      op_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant;
        a_q <= a_sel;
        shamt_q <= shamt_sel;
        op_q <= op_sel;
      end
      if (state_q == SHIFT) rsp_data_q <= res;
    end
  end
  // Ready is gated by reset so nothing is offered while the block is held in reset.
  assign req_ready_o = (accept && rst_ni) ? ONE << grant : '0;
  assign rsp_valid_o = state_q == RESP ? ONE << owner_q : '0;
  assign rsp_data_o = rsp_data_q;
  assign sh_a_o = state_q == SHIFT ? (op_q[0] ? a_rev : a_q) : '0;
  assign sh_shamt_o = state_q == SHIFT ? shamt_q : '0;
endmodule
